// File: rtl/bcd_to_binary_pkg.sv
// Shared types and constants for the BCD-to-binary converter.
package bcd_to_binary_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        CONV = 1'b1
    } state_e;

    localparam int DIGIT_W = 4;
    localparam int BCD_MAX = 9;

    // Digit counter width; a single-digit build still gets a 1-bit counter.
    function automatic int cnt_w(input int digits);
        return (digits > 1) ? $clog2(digits) : 1;
    endfunction

endpackage

// File: rtl/bcd_to_binary_mac_step.sv
// One multiply-by-10-and-add step of the BCD accumulation, purely combinational.
module bcd_mac_step
    import bcd_to_binary_pkg::*;
#(
    parameter int WIDTH = 20
) (
    input  logic [WIDTH-1:0]   acc,
    input  logic [DIGIT_W-1:0] digit,
    output logic [WIDTH-1:0]   acc_next,
    output logic               digit_bad
);

    logic [WIDTH-1:0] acc_x10;

    // Shifts drop the high bits, so the result wraps modulo 2^WIDTH.
    assign acc_x10   = (acc << 3) + (acc << 1);
    assign acc_next  = acc_x10 + WIDTH'(digit);
    assign digit_bad = (digit > DIGIT_W'(BCD_MAX));

endmodule

// File: rtl/bcd_to_binary.sv
// Sequential BCD-to-binary converter, one digit per clock, MSD first.
// Optional non-decimal digit checking is enabled by defining BCD_DIGIT_CHECK_EN.
module bcd_to_binary
    import bcd_to_binary_pkg::*;
#(
    parameter int DIGITS = 6,
    parameter int WIDTH  = 20
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [DIGIT_W*DIGITS-1:0] bcd_in,
    output logic                      ready,
    output logic [WIDTH-1:0]          value,
    output logic                      done,
    output logic                      err
);

    localparam int CNT_W = cnt_w(DIGITS);
    localparam int SR_W  = DIGIT_W * DIGITS;

    state_e           state_q, state_d;
    logic [SR_W-1:0]  sr_q, sr_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] value_q, value_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0]   acc_next;
    logic               digit_bad;
    logic [DIGIT_W-1:0] cur_digit;
    logic               last_digit;

    assign cur_digit  = sr_q[SR_W-1 -: DIGIT_W];
    assign last_digit = (cnt_q == CNT_W'(DIGITS - 1));

    bcd_mac_step #(
        .WIDTH (WIDTH)
    ) u_mac (
        .acc       (acc_q),
        .digit     (cur_digit),
        .acc_next  (acc_next),
        .digit_bad (digit_bad)
    );

`ifdef BCD_DIGIT_CHECK_EN
    logic err_q, err_d;
    logic err_pend_q, err_pend_d;
    logic conv_bad;

    assign conv_bad = err_pend_q | digit_bad;
`else
    logic unused_digit_bad;
    assign unused_digit_bad = digit_bad;
`endif

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        value_d = value_q;
        done_d  = 1'b0;
`ifdef BCD_DIGIT_CHECK_EN
        err_d      = err_q;
        err_pend_d = err_pend_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    sr_d    = bcd_in;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = CONV;
`ifdef BCD_DIGIT_CHECK_EN
                    err_pend_d = 1'b0;
`endif
                end
            end
            CONV: begin
                sr_d  = sr_q << DIGIT_W;
                acc_d = acc_next;
                cnt_d = cnt_q + CNT_W'(1);
`ifdef BCD_DIGIT_CHECK_EN
                err_pend_d = conv_bad;
`endif
                if (last_digit) begin
                    value_d = acc_next;
                    done_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = IDLE;
`ifdef BCD_DIGIT_CHECK_EN
                    err_d = conv_bad;
                    if (conv_bad) begin
                        value_d = '0;
                    end
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sr_q    <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            value_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            value_q <= value_d;
            done_q  <= done_d;
        end
    end

`ifdef BCD_DIGIT_CHECK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q      <= 1'b0;
            err_pend_q <= 1'b0;
        end else begin
            err_q      <= err_d;
            err_pend_q <= err_pend_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign ready = (state_q == IDLE);
    assign value = value_q;
    assign done  = done_q;

endmodule

// File: doc/bcd_to_binary.md
# bcd_to_binary

Sequential BCD-to-binary converter: accepts a packed group of decimal digits, for example from keypad or switch digit entry, and produces the equivalent unsigned binary value. It is the inverse of the binary-to-decimal digit split that feeds the seven-segment display path. It lets user-entered decimal values be compared with, or loaded into, the binary counters and registers elsewhere in the design. It uses one multiply-by-10-and-add step per clock, with MSD first.

## Interface
Parameters:
- DIGITS, 6, number of BCD digits in the input word.
- WIDTH, 20, width of the binary result. Requirement: 10^DIGITS − 1 < 2^WIDTH; if violated, the result is taken modulo 2^WIDTH.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  conversion request; sampled only while ready=1.
- bcd_in  in  4*DIGITS  packed digits; [4*DIGITS-1 -: 4] is the MSD, [3:0] is the LSD.
- ready  out  1  high in IDLE.
- value  out  WIDTH  last converted result; registered; held until the next completion.
- done  out  1  one-cycle pulse when value/err update.
- err  out  1  non-decimal digit detected in the last conversion (see Configuration).

## Operation
- States are IDLE, CONV.
- IDLE:
  - ready=1.
  - start=1 at an edge latches bcd_in into the shift register, clears acc and the digit counter, clears err_pend, and moves to CONV.
  - bcd_in is not sampled again for that conversion.
- CONV:
  - ready=0.
  - Each edge computes acc ← acc*10 + d, where d is the current top nibble of the shift register; the register then shifts left 4 bits and the counter increments.
  - acc*10 is computed as (acc<<3)+(acc<<1), truncated to WIDTH bits.
  - The digit is zero-extended to WIDTH bits.
- Last digit (counter = DIGITS−1):
  - value ← acc*10 + d (or 0 on error, see Configuration).
  - err ← err_pend | current-digit error.
  - done ← 1.
  - The state returns to IDLE.
- start while ready=0 is ignored; no queuing.
- done is 0 in every cycle except the one following a completion edge.
- value and err hold their values between completions.
- Reset (any time, including mid-conversion): state=IDLE, ready=1, value=0, done=0, err=0, acc=0, counter=0. An in-flight conversion is dropped with no done pulse.

## Timing
- Start accepted at edge E0; digits are accumulated at edges E1..E_DIGITS.
- value, err and done are valid in the cycle after edge E_DIGITS; latency is DIGITS edges (6 by default).
- ready rises together with done.
- A start held high is accepted at the edge ending the done cycle.
- Throughput: one conversion per DIGITS+1 cycles.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- BCD_DIGIT_CHECK_EN defined:
  - Each digit > 9 sets err_pend.
  - At completion, if any digit was invalid: value=0, err=1, done pulses normally.
- BCD_DIGIT_CHECK_EN undefined:
  - No check is made; err is tied to 0.
  - Nibbles 10..15 are accumulated with their raw weight (acc*10 + nibble).

## Structure
- Shared package:
  - state enum (IDLE, CONV);
  - DIGIT_W=4;
  - BCD_MAX=9;
  - helper constant for counter width, $clog2(DIGITS).
- Sub-module bcd_mac_step, purely combinational:
  - inputs: acc[WIDTH-1:0], digit[3:0];
  - outputs: next acc (acc*10+digit), digit_bad (digit > BCD_MAX).
- The top-level block holds the FSM, shift register, counter and output registers.

## Test plan
- bcd_in=24'h123456, start pulse → exactly 6 edges later value=123456 (20'h1E240), err=0, done high for 1 cycle; ready low for 6 cycles.
- bcd_in=24'h999999 → value=999999 (20'hF423F), no truncation; then bcd_in=24'h000000 → value=0, done pulses.
- bcd_in=24'h12A456:
  - with BCD_DIGIT_CHECK_EN → value=0, err=1;
  - without it → value=130456, err=0;
  - a following valid conversion of 24'h000042 → value=42, err=0.
- start held high continuously with bcd_in=24'h000007 → conversions complete every 7 cycles; bcd_in changes during CONV do not affect the result.
- rst asserted during the 3rd CONV cycle of 24'h654321 → immediately ready=1, value=0, done=0; no done pulse follows; the next start converts correctly.
